sha256_round_ctrl: RTL and testbench

Sequencing controller for the combinational SHA-256 round datapath (`SHA256_compression`). It accepts one padded 512-bit message block, loads the working state, and drives the datapath for 64 rounds while supplying Kt from an internal constant ROM and Wt from an internal 16-word message-schedule window. It then adds the working state into the chaining hash and presents the 256-bit digest on a valid/yumi handshake. It sits between the FSB-facing message buffer and the round datapath.

---
 rtl/sha256_round_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// Purpose : sequences one 512-bit block through 64 rounds of an external combinational
//           SHA-256 round datapath, supplying K[t] from ROM and W[t] from a 16-word window,
//           then adds the working state into the hash and presents the digest.
// Latency : block accepted in cycle c -> ROUND c+1..c+64 -> FINAL c+65 -> v_o from c+66.
// Backpr. : ready_o is high only in IDLE; the digest is held in DONE until yumi_i.
// Ports   : clk_i/reset_i (sync, active-high); v_i/block_i/first_i/ready_o input block;
//           round_state_o/kt_o/wt_o to datapath, round_state_i back; v_o/digest_o/yumi_i out.
// Option  : define SHA256_ROUND_CTRL_CHAIN_EN to chain blocks (first_i selects IV vs digest).
module sha256_round_ctrl (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    input  logic [511:0] block_i,
    input  logic         first_i,
    output logic         ready_o,
    output logic [255:0] round_state_o,
    output logic [31:0]  kt_o,
    output logic [31:0]  wt_o,
    input  logic [255:0] round_state_i,
    output logic         v_o,
    output logic [255:0] digest_o,
    input  logic         yumi_i
);

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    // Listed K[0] first, so K[0] lands at index 63: index with ~t (== 63 - t).
    localparam logic [63:0][31:0] K_ROM = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    state_e             state_q, state_d;
    logic [5:0]         t_q;
    logic [15:0][31:0]  w_q;       // w_q[0] is W[t], w_q[15] is W[t+15]
    logic [255:0]       work_q;
    logic [255:0]       digest_q;
    logic [255:0]       hin_load;  // Hin chosen at accept time
    logic [255:0]       hin_final; // same Hin, recalled in FINAL
    logic [255:0]       digest_sum;
    logic [31:0]        w_next;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef SHA256_ROUND_CTRL_CHAIN_EN
    logic [255:0] chain_q;
    logic         first_q;  // first_i of the block in flight

    assign hin_load  = first_i ? IV : chain_q;
    // chain_q only changes in FINAL, so it still equals the value used at accept.
    assign hin_final = first_q ? IV : chain_q;
`else
    logic unused_first;

    assign unused_first = first_i;
    assign hin_load     = IV;
    assign hin_final    = IV;
`endif

    assign w_next = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    always_comb begin
        digest_sum = '0;
        for (int i = 0; i < 8; i++) begin
            digest_sum[32*i +: 32] = hin_final[32*i +: 32] + work_q[32*i +: 32];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) state_d = ROUND;
            end
            ROUND: begin
                if (t_q == 6'd63) state_d = FINAL;
            end
            FINAL: begin
                state_d = DONE;
            end
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            t_q      <= '0;
            w_q      <= '0;
            work_q   <= '0;
            digest_q <= '0;
`ifdef SHA256_ROUND_CTRL_CHAIN_EN
            chain_q  <= IV;
            first_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_i) begin
                        // Message word 0 sits in the top bits of block_i.
                        for (int i = 0; i < 16; i++) begin
                            w_q[i] <= block_i[32*(15-i) +: 32];
                        end
                        work_q <= hin_load;
                        t_q    <= '0;
`ifdef SHA256_ROUND_CTRL_CHAIN_EN
                        first_q <= first_i;
`endif
                    end
                end
                ROUND: begin
                    work_q <= round_state_i;
                    w_q    <= {w_next, w_q[15:1]};
                    // Exit is decoded at t==63, so the increment to 0 happens only on leaving.
                    t_q    <= t_q + 6'd1;
                end
                FINAL: begin
                    digest_q <= digest_sum;
`ifdef SHA256_ROUND_CTRL_CHAIN_EN
                    chain_q  <= digest_sum;
`endif
                end
                default: ;
            endcase
        end
    end

    assign round_state_o = work_q;
    assign kt_o          = K_ROM[~t_q];
    assign wt_o          = w_q[0];
    assign digest_o      = digest_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Purpose : directed bench for sha256_round_ctrl with a behavioural SHA-256 round datapath.
// Latency : checks accept-to-v_o latency of 66 cycles and ready_o return one cycle after yumi_i.
// Backpr. : holds yumi_i low in DONE and pulses v_i to show the block is refused.
module tb_sha256_round_ctrl;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic [511:0] block_i;
    logic         first_i;
    logic         ready_o;
    logic [255:0] round_state_o;
    logic [31:0]  kt_o;
    logic [31:0]  wt_o;
    logic [255:0] round_state_i;
    logic         v_o;
    logic [255:0] digest_o;
    logic         yumi_i;

    localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
`ifdef SHA256_ROUND_CTRL_CHAIN_EN
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] BLK_TWO_1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO_2 = {480'h0, 32'h000001c0};
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    sha256_round_ctrl dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .block_i       (block_i),
        .first_i       (first_i),
        .ready_o       (ready_o),
        .round_state_o (round_state_o),
        .kt_o          (kt_o),
        .wt_o          (wt_o),
        .round_state_i (round_state_i),
        .v_o           (v_o),
        .digest_o      (digest_o),
        .yumi_i        (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 compression round standing in for the external datapath.
    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    always_comb round_state_i = sha_round(round_state_o, kt_o, wt_o);

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 256'(ready_o), 256'(1));
        check({tag, "_v"},     256'(v_o), 256'(0));
        check({tag, "_digest"}, digest_o, 256'h0);
        check({tag, "_state"}, round_state_o, 256'h0);
        check({tag, "_kt"},    256'(kt_o), 256'(32'h428a2f98));
        check({tag, "_wt"},    256'(wt_o), 256'(0));
    endtask

    // Presents one block for a single cycle; returns in the first ROUND cycle (cyc=1).
    task automatic send(input logic [511:0] blk, input logic f);
        v_i     = 1'b1;
        block_i = blk;
        first_i = f;
        tick();
        v_i     = 1'b0;
        cyc     = 1;
    endtask

    task automatic wait_valid();
        while (!v_o && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        block_i = '0;
        first_i = 1'b0;
        yumi_i  = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        reset_i = 1'b0;

        // "abc", yumi tied high
        yumi_i = 1'b1;
        check("idle_ready", 256'(ready_o), 256'(1));
        send(BLK_ABC, 1'b1);
        check("r0_ready", 256'(ready_o), 256'(0));
        check("r0_state", round_state_o, IV);
        check("r0_kt", 256'(kt_o), 256'(32'h428a2f98));
        check("r0_wt", 256'(wt_o), 256'(32'h61626380));
        tick();
        cyc++;
        check("r1_kt", 256'(kt_o), 256'(32'h71374491));
        check("r1_wt", 256'(wt_o), 256'(0));
        wait_valid();
        check("abc_latency", 256'(cyc), 256'(66));
        check("abc_digest", digest_o, DIG_ABC);
        tick();
        check("abc_ready_back", 256'(ready_o), 256'(1));
        check("abc_v_drop", 256'(v_o), 256'(0));
        yumi_i = 1'b0;

        // yumi in IDLE is ignored
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        check("idle_yumi_v", 256'(v_o), 256'(0));
        check("idle_yumi_ready", 256'(ready_o), 256'(1));

        // empty message, yumi pulses during ROUND
        send(BLK_EMPTY, 1'b1);
        while (!v_o && cyc < 200) begin
            yumi_i = (cyc == 10 || cyc == 40);
            tick();
            if (cyc == 10 || cyc == 40) check("round_yumi_v", 256'(v_o), 256'(0));
            cyc++;
        end
        yumi_i = 1'b0;
        check("empty_latency", 256'(cyc), 256'(66));
        check("empty_digest", digest_o, DIG_EMPTY);

        // backpressure in DONE with a pulsed block
        for (int i = 0; i < 20; i++) begin
            v_i     = (i == 5);
            block_i = BLK_ABC;
            first_i = 1'b1;
            tick();
            check("bp_v", 256'(v_o), 256'(1));
            check("bp_digest", digest_o, DIG_EMPTY);
            check("bp_ready", 256'(ready_o), 256'(0));
        end
        v_i    = 1'b0;
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        check("bp_release_ready", 256'(ready_o), 256'(1));
        check("bp_release_v", 256'(v_o), 256'(0));
        tick();
        check("bp_not_accepted", 256'(ready_o), 256'(1));

        // reset in the middle of ROUND at t=30
        send(BLK_ABC, 1'b1);
        for (int i = 0; i < 30; i++) tick();
        check("t30_kt", 256'(kt_o), 256'(32'h06ca6351));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_reset_values("midrst");
        send(BLK_ABC, 1'b0);
        wait_valid();
        check("post_rst_latency", 256'(cyc), 256'(66));
        check("post_rst_digest", digest_o, DIG_ABC);
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;

`ifdef SHA256_ROUND_CTRL_CHAIN_EN
        // two-block message chained through the previous digest
        send(BLK_TWO_1, 1'b1);
        wait_valid();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        send(BLK_TWO_2, 1'b0);
        wait_valid();
        check("two_block_digest", digest_o, DIG_TWO);
`else
        // without chaining, first_i=0 still starts from IV
        send(BLK_EMPTY, 1'b0);
        wait_valid();
        check("nochain_digest", digest_o, DIG_EMPTY);
`endif
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        check("end_ready", 256'(ready_o), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
